// File: rtl/seed_gf_pkg.sv
// GF(2^8) constants and helpers for the SEED S2 datapath (field poly 0x163).
// Holds the S2 affine matrix, its GF(2) inverse, the exponents and the FSM enums.
package seed_gf_pkg;

    localparam logic [7:0] POLY       = 8'h63;
    localparam logic [7:0] S2_CONST   = 8'h38;
    localparam logic [7:0] EXP_S2     = 8'd251;
    localparam logic [7:0] EXP_S2_INV = 8'd191;

    // Element [i] is the row producing output bit i; each row is a mask over p[7:0].
    localparam logic [7:0][7:0] A2 = {
        8'h45, 8'h85, 8'hFE, 8'h21, 8'h8A, 8'h88, 8'h42, 8'h14
    };
    localparam logic [7:0][7:0] A2_INV = {
        8'hCE, 8'h0E, 8'h27, 8'hB8, 8'hCA, 8'hB9, 8'h0C, 8'h37
    };

    typedef enum logic [1:0] {IDLE, EXP, DONE} state_t;
    typedef enum logic {SQ, MUL} phase_t;

    function automatic logic [7:0] mat_vec(input logic [7:0][7:0] m, input logic [7:0] v);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) begin
            r[i] = ^(m[i] & v);
        end
        return r;
    endfunction

endpackage

// File: rtl/gf256_mul.sv
// Combinational GF(2^8) multiply, reduced by x^8 + POLY.
// Latency: zero (pure logic). Backpressure: none, no state.
module gf256_mul #(
    parameter logic [7:0] POLY = 8'h63
) (
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic [7:0] p
);

    logic [7:0] sh;

    // Shift-and-add: sh holds a*x^i already reduced, so p never exceeds 8 bits.
    always_comb begin
        p  = 8'h00;
        sh = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                p = p ^ sh;
            end
            sh = {sh[6:0], 1'b0} ^ (sh[7] ? POLY : 8'h00);
        end
    end

endmodule

// File: rtl/seed_s2_inv_serial.sv
// Serial SEED S2^-1 (optional forward S2 with SEED_S2_FWD_EN) using one shared GF(2^8) multiplier.
// Latency: result valid 13 edges after the accept edge, fixed for every input.
// Backpressure: in_ready low while busy; result held in DONE until out_ready, no buffering.
module seed_s2_inv_serial #(
    parameter logic [7:0] POLY    = 8'h63,
    parameter logic [7:0] INV_EXP = 8'd191
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
`ifdef SEED_S2_FWD_EN
    input  logic       mode,
`endif
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data
);
    import seed_gf_pkg::*;

    state_t     state, state_n;
    phase_t     phase, phase_n;
    logic [2:0] idx, idx_n;
    logic [7:0] acc, acc_n;
    logic [7:0] z_reg, z_n;
    logic [7:0] z_in;
    logic [7:0] exp_sel;
    logic [7:0] done_val;
    logic [7:0] mul_b;
    logic [7:0] mul_p;
    logic       last;

`ifdef SEED_S2_FWD_EN
    logic mode_reg, mode_n;

    always_comb begin
        z_in     = mode ? in_data : mat_vec(A2_INV, in_data ^ S2_CONST);
        exp_sel  = mode_reg ? EXP_S2 : INV_EXP;
        done_val = mode_reg ? (mat_vec(A2, mul_p) ^ S2_CONST) : mul_p;
    end
`else
    always_comb begin
        z_in     = mat_vec(A2_INV, in_data ^ S2_CONST);
        exp_sel  = INV_EXP;
        done_val = mul_p;
    end
`endif

    assign mul_b = (phase == SQ) ? acc : z_reg;

    gf256_mul #(.POLY(POLY)) u_mul (
        .a (acc),
        .b (mul_b),
        .p (mul_p)
    );

    always_comb begin
        state_n = state;
        phase_n = phase;
        idx_n   = idx;
        acc_n   = acc;
        z_n     = z_reg;
        last    = 1'b0;
`ifdef SEED_S2_FWD_EN
        mode_n  = mode_reg;
`endif
        case (state)
            IDLE: begin
                if (in_valid) begin
                    acc_n   = z_in;
                    z_n     = z_in;
                    idx_n   = 3'd6;
                    phase_n = SQ;
                    state_n = EXP;
`ifdef SEED_S2_FWD_EN
                    mode_n  = mode;
`endif
                end
            end
            EXP: begin
                acc_n = mul_p;
                // Exponent MSB is always 1 and is covered by loading acc with z.
                if (phase == SQ && exp_sel[idx]) begin
                    phase_n = MUL;
                end else begin
                    phase_n = SQ;
                    if (idx == 3'd0) begin
                        last = 1'b1;
                    end else begin
                        idx_n = idx - 3'd1;
                    end
                end
                if (last) begin
                    state_n = DONE;
                    acc_n   = done_val;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            phase    <= SQ;
            idx      <= 3'd0;
            acc      <= 8'h00;
            z_reg    <= 8'h00;
`ifdef SEED_S2_FWD_EN
            mode_reg <= 1'b0;
`endif
        end else begin
            state    <= state_n;
            phase    <= phase_n;
            idx      <= idx_n;
            acc      <= acc_n;
            z_reg    <= z_n;
`ifdef SEED_S2_FWD_EN
            mode_reg <= mode_n;
`endif
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign out_data  = acc;

endmodule

// File: tb/tb_seed_s2_inv_serial.sv
// Bench for seed_s2_inv_serial: table-based S2 model, per-cycle handshake/latency compare,
// plus directed vectors with literal expectations.
module tb_seed_s2_inv_serial;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b1;
    logic [7:0] in_data = 8'h00;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_data;
`ifdef SEED_S2_FWD_EN
    logic       mode = 1'b0;
`endif

    always #5 clk = ~clk;

    seed_s2_inv_serial dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
`ifdef SEED_S2_FWD_EN
        .mode      (mode),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] s2_tbl  [256];
    logic [7:0] inv_tbl [256];

    // Full polynomial product, then long division by 0x163.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = 16'h0000;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ (16'(a) << i);
        end
        for (int k = 15; k >= 8; k--) begin
            if (p[k]) p = p ^ (16'h0163 << (k - 8));
        end
        return p[7:0];
    endfunction

    function automatic logic [7:0] gpow(input logic [7:0] a, input int e);
        logic [7:0] r;
        r = 8'h01;
        for (int i = 0; i < e; i++) r = gmul(r, a);
        return r;
    endfunction

    function automatic logic [7:0] a2(input logic [7:0] p);
        logic [7:0] r;
        r[7] = p[6] ^ p[2] ^ p[0];
        r[6] = p[7] ^ p[2] ^ p[0];
        r[5] = p[7] ^ p[6] ^ p[5] ^ p[4] ^ p[3] ^ p[2] ^ p[1];
        r[4] = p[5] ^ p[0];
        r[3] = p[7] ^ p[3] ^ p[1];
        r[2] = p[7] ^ p[3];
        r[1] = p[6] ^ p[1];
        r[0] = p[4] ^ p[2];
        return r;
    endfunction

    task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: no handshake within budget, expected one (cycle %0d)", name, cyc);
    endtask

    // Reference model: busy flag, accept cycle and expected result of the one in-flight byte.
    bit         armed = 1'b0;
    bit         busy = 1'b0;
    bit         exp_ov;
    int         acc_cyc = 0;
    logic [7:0] exp_val = 8'h00;

    always @(negedge clk) begin
        exp_ov = busy && (cyc - acc_cyc >= 13);
        if (armed) begin
            chk1("in_ready", in_ready, !busy);
            chk1("out_valid", out_valid, exp_ov);
            if (exp_ov) chk8("out_data", out_data, exp_val);
        end
        if (rst) begin
            busy  = 1'b0;
            armed = 1'b1;
        end else if (in_valid && !busy) begin
            busy    = 1'b1;
            acc_cyc = cyc + 1;
`ifdef SEED_S2_FWD_EN
            exp_val = mode ? s2_tbl[in_data] : inv_tbl[in_data];
`else
            exp_val = inv_tbl[in_data];
`endif
        end else if (exp_ov && out_ready) begin
            busy = 1'b0;
        end
    end

    task automatic send(input logic [7:0] b, output int acc_at);
        int n;
        n = 0;
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 200) timeout_fail("send");
        @(posedge clk);
        #1;
        acc_at   = cyc;
        in_valid = 1'b0;
    endtask

    task automatic wait_out(input int acc_at, output int lat);
        int n;
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) timeout_fail("wait_out");
        lat = cyc - acc_at;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int a, lat, prev;

        for (int x = 0; x < 256; x++) begin
            s2_tbl[x] = a2(gpow(x[7:0], 251)) ^ 8'h38;
            inv_tbl[s2_tbl[x]] = x[7:0];
        end
        chk8("model_mul", gmul(8'h02, 8'h80), 8'h63);
        chk8("model_s2_00", s2_tbl[0], 8'h38);
        chk8("model_s2_01", s2_tbl[1], 8'hE8);
        chk8("model_inv_e8", inv_tbl[8'hE8], 8'h01);

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk1("rst_in_ready", in_ready, 1'b1);
        chk1("rst_out_valid", out_valid, 1'b0);
        chk8("rst_out_data", out_data, 8'h00);

        send(8'h38, a);
        wait_out(a, lat);
        chk_int("lat_38", lat, 13);
        chk8("data_38", out_data, 8'h00);

        send(8'hE8, a);
        wait_out(a, lat);
        chk_int("lat_e8", lat, 13);
        chk8("data_e8", out_data, 8'h01);

        prev = 0;
        for (int x = 0; x < 256; x++) begin
            send(s2_tbl[x], a);
            if (x > 0) chk_int("spacing", a - prev, 15);
            prev = a;
            wait_out(a, lat);
            chk8("sweep", out_data, x[7:0]);
        end

        @(posedge clk);
        #1;
        out_ready = 1'b0;
        send(8'hE8, a);
        wait_out(a, lat);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk1("stall_valid", out_valid, 1'b1);
            chk8("stall_data", out_data, 8'h01);
            chk1("stall_in_ready", in_ready, 1'b0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk1("release_valid", out_valid, 1'b0);
        chk1("release_in_ready", in_ready, 1'b1);

        send(8'h38, a);
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk1("abort_valid", out_valid, 1'b0);
        chk1("abort_in_ready", in_ready, 1'b1);
        chk8("abort_data", out_data, 8'h00);
        send(8'hE8, a);
        wait_out(a, lat);
        chk_int("lat_after_abort", lat, 13);
        chk8("data_after_abort", out_data, 8'h01);

`ifdef SEED_S2_FWD_EN
        @(posedge clk);
        #1;
        mode = 1'b1;
        send(8'h00, a);
        wait_out(a, lat);
        chk_int("fwd_lat_00", lat, 13);
        chk8("fwd_00", out_data, 8'h38);
        send(8'h01, a);
        wait_out(a, lat);
        chk_int("fwd_lat_01", lat, 13);
        chk8("fwd_01", out_data, 8'hE8);
        @(posedge clk);
        #1;
        mode = 1'b0;
`endif

        @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
